// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: coin codes, their cent values,
// the debouncer state encoding and the credit width.
package coin_pkg;

  localparam int CODE_W   = 4;
  localparam int CREDIT_W = 10;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;
  localparam logic [CODE_W-1:0] NICKEL    = 4'd1;
  localparam logic [CODE_W-1:0] DIME      = 4'd2;
  localparam logic [CODE_W-1:0] QUARTER   = 4'd3;
  localparam logic [CODE_W-1:0] DOLLAR    = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_WAIT_REL
  } deb_state_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [CODE_W-1:0] code);
    case (code)
      NICKEL:  return 10'd5;
      DIME:    return 10'd10;
      QUARTER: return 10'd25;
      DOLLAR:  return 10'd100;
      default: return '0;
    endcase
  endfunction

  function automatic logic coin_is_valid(input logic [CODE_W-1:0] code);
    return (code >= NICKEL) && (code <= DOLLAR);
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO with a registered head output; the head reads 0
// whenever the FIFO is empty.
module coin_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]      count, count_n;
  logic [WIDTH-1:0] head_n;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign count_n  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // The entry being written becomes the head only when nothing else remains.
  always_comb begin
    head_n = '0;
    if (count_n == '0)
      head_n = '0;
    else if (do_push && (count == (AW+1)'(do_pop)))
      head_n = din;
    else
      head_n = mem[rd_ptr_n];
  end

  // NOTE: storage has no reset; occupancy and the head register alone define what is visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      dout   <= head_n;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the slot sensor, queues accepted coins for the
// vending FSM, keeps a saturating credit total and pulses reject on returns.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [CODE_W-1:0]   coin_raw,
  output logic [CODE_W-1:0]   coin_code,
  output logic                coin_valid,
  input  logic                coin_ready,
  output logic [CREDIT_W-1:0] credit,
  input  logic                credit_clr,
  output logic                reject,
  output logic                busy
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  deb_state_t          state, state_n;
  logic [CODE_W-1:0]   latched, latched_n;
  logic [3:0]          cnt, cnt_n;
  logic                deb_event;
  logic                fifo_full, fifo_empty, pop, accept;
  logic [CREDIT_W-1:0] credit_base, credit_n;
  logic [CREDIT_W:0]   credit_sum;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      latched <= CODE_NONE;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      latched <= latched_n;
      cnt     <= cnt_n;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state;
    latched_n = latched;
    cnt_n     = cnt;
    case (state)
      ST_IDLE: begin
        if (coin_raw != CODE_NONE) begin
          latched_n = coin_raw;
          cnt_n     = 4'd1;
          state_n   = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (coin_raw == CODE_NONE) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (coin_raw != latched) begin
          latched_n = coin_raw;
          cnt_n     = 4'd1;
        end else if (deb_event) begin
          cnt_n   = '0;
          state_n = ST_WAIT_REL;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      ST_WAIT_REL: begin
        if (coin_raw == CODE_NONE) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    deb_event = (state == ST_COUNT) && (coin_raw == latched) && (cnt == DEB_LAST);
  end

  assign coin_valid = !fifo_empty;
  assign pop        = coin_valid && coin_ready;
  // A full FIFO still takes the coin when the consumer frees a slot this cycle.
  assign accept     = deb_event && coin_is_valid(latched) && (!fifo_full || pop);

  coin_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (accept),
    .din   (latched),
    .pop   (pop),
    .dout  (coin_code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign credit_base = credit_clr ? '0 : credit;
  assign credit_sum  = {1'b0, credit_base} + {1'b0, coin_value(latched)};

  always_comb begin
    credit_n = credit_base;
    if (accept) credit_n = credit_sum[CREDIT_W] ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      credit <= '0;
      reject <= 1'b0;
    end else begin
      credit <= credit_n;
      reject <= deb_event && !accept;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios followed by random
// slot activity, all compared each cycle against a queue-based reference model.
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] coin_raw = 4'd0;
  logic       coin_ready = 1'b0;
  logic       credit_clr = 1'b0;
  logic [3:0] coin_code;
  logic       coin_valid;
  logic [9:0] credit;
  logic       reject;
  logic       busy;

  always #5 clock = ~clock;

  coin_acceptor #(
    .DEB_CYCLES (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .coin_raw   (coin_raw),
    .coin_code  (coin_code),
    .coin_valid (coin_valid),
    .coin_ready (coin_ready),
    .credit     (credit),
    .credit_clr (credit_clr),
    .reject     (reject),
    .busy       (busy)
  );

  // Reference model: queued coins, credit total, and the length of the
  // current unbroken run of one nonzero sensor code.
  int q[$];
  int m_credit;
  int run_code;
  int run_len;
  bit hold;
  bit m_reject;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int cents(input int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 25;
      4: return 100;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_credit = 0;
    run_code = 0;
    run_len  = 0;
    hold     = 1'b0;
    m_reject = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    bit ev;
    int ev_code;
    pop     = (q.size() > 0) && coin_ready;
    ev      = 1'b0;
    ev_code = 0;
    if (hold) begin
      if (coin_raw == 4'd0) hold = 1'b0;
    end else if (coin_raw == 4'd0) begin
      run_len = 0;
    end else begin
      if (int'(coin_raw) == run_code) run_len++;
      else begin
        run_code = int'(coin_raw);
        run_len  = 1;
      end
      if (run_len == DEB) begin
        ev      = 1'b1;
        ev_code = run_code;
        hold    = 1'b1;
        run_len = 0;
      end
    end
    if (credit_clr) m_credit = 0;
    m_reject = 1'b0;
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (cents(ev_code) == 0) m_reject = 1'b1;
      else if (q.size() < DEPTH) begin
        q.push_back(ev_code);
        m_credit = (m_credit + cents(ev_code) > 1023) ? 1023 : m_credit + cents(ev_code);
      end else m_reject = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("coin_valid", 32'(coin_valid), 32'(q.size() > 0));
    check("coin_code",  32'(coin_code),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("credit",     32'(credit),     32'(m_credit));
    check("reject",     32'(reject),     32'(m_reject));
    check("busy",       32'(busy),       32'(hold || (run_len > 0)));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic drive(input logic [3:0] raw, input logic rdy, input logic clr, input int n);
    coin_raw   = raw;
    coin_ready = rdy;
    credit_clr = clr;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    rst = 1'b1;

    // Quarter held long enough, consumer ready: one coin passes straight through.
    drive(4'd3, 1'b1, 1'b0, 6);
    drive(4'd0, 1'b1, 1'b0, 2);
    check("quarter_credit", 32'(credit), 32'd25);

    // Bounce shorter than the debounce window leaves no trace.
    drive(4'd0, 1'b1, 1'b1, 1);
    drive(4'd2, 1'b1, 1'b0, DEB - 1);
    drive(4'd0, 1'b1, 1'b0, 2);
    check("short_credit", 32'(credit), 32'd0);
    check("short_busy",   32'(busy),   32'd0);

    // Five dollars into a stalled consumer: the fifth overflows and is returned.
    for (int i = 0; i < 5; i++) begin
      drive(4'd4, 1'b0, 1'b0, DEB + 1);
      drive(4'd0, 1'b0, 1'b0, 1);
    end
    check("full_credit", 32'(credit),     32'd400);
    check("full_valid",  32'(coin_valid), 32'd1);
    drive(4'd0, 1'b1, 1'b0, 5);
    drive(4'd0, 1'b1, 1'b1, 1);

    // Unknown code is rejected once, however long it is held.
    drive(4'd9, 1'b1, 1'b0, 6);
    drive(4'd0, 1'b1, 1'b0, 1);
    check("bad_credit", 32'(credit), 32'd0);

    // Saturation at 1023, then clear coinciding with a quarter.
    for (int i = 0; i < 10; i++) begin
      drive(4'd4, 1'b1, 1'b0, DEB);
      drive(4'd0, 1'b1, 1'b0, 1);
    end
    check("credit_1000", 32'(credit), 32'd1000);
    drive(4'd4, 1'b1, 1'b0, DEB);
    drive(4'd0, 1'b1, 1'b0, 1);
    check("credit_sat", 32'(credit), 32'd1023);
    drive(4'd3, 1'b1, 1'b0, DEB - 1);
    drive(4'd3, 1'b1, 1'b1, 1);
    check("clr_add", 32'(credit), 32'd25);
    drive(4'd0, 1'b1, 1'b0, 2);

    // Reset mid-debounce with two coins queued.
    drive(4'd0, 1'b1, 1'b1, 1);
    drive(4'd1, 1'b0, 1'b0, DEB);
    drive(4'd0, 1'b0, 1'b0, 1);
    drive(4'd2, 1'b0, 1'b0, DEB);
    drive(4'd0, 1'b0, 1'b0, 1);
    drive(4'd3, 1'b0, 1'b0, 2);
    #2 rst = 1'b0;
    #1;
    check("rst_valid",  32'(coin_valid), 32'd0);
    check("rst_code",   32'(coin_code),  32'd0);
    check("rst_credit", 32'(credit),     32'd0);
    check("rst_reject", 32'(reject),     32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    model_reset();
    @(negedge clock);
    rst = 1'b1;
    drive(4'd3, 1'b0, 1'b0, DEB - 1);
    check("post_rst_early", 32'(coin_valid), 32'd0);
    drive(4'd3, 1'b0, 1'b0, 1);
    check("post_rst_valid", 32'(coin_valid), 32'd1);
    check("post_rst_code",  32'(coin_code),  32'd3);
    drive(4'd0, 1'b1, 1'b0, 3);

    // Random slot activity with random consumer stalls and occasional clears.
    for (int r = 0; r < 150; r++) begin
      int sel;
      int len;
      logic [3:0] code;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    code = 4'd0;
        2:       code = 4'd1;
        3:       code = 4'd2;
        4:       code = 4'd3;
        5, 6:    code = 4'd4;
        7:       code = 4'($urandom_range(5, 15));
        default: code = 4'($urandom_range(1, 4));
      endcase
      len = int'($urandom_range(1, 7));
      for (int c = 0; c < len; c++) begin
        drive(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
